// File: rtl/sdr_duc_receive.sv
// Receive-side DUC I/Q parser: strips the 32-bit sequence number from each UDP payload,
// packs 24-bit big-endian I/Q pairs into 48-bit FIFO words and tracks sequence/short/overflow errors.
module sdr_duc_receive #(
  parameter logic [15:0] RX_PORT = 16'd1029,
  parameter int          SAMPLES = 240
) (
  input  logic        rx_clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        udp_rx_active,
  input  logic [7:0]  udp_rx_data,
  input  logic [15:0] to_port,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [47:0] fifo_wdata,
  output logic        seq_error,
  output logic [15:0] seq_err_count,
  output logic [15:0] overflow_count,
  output logic [7:0]  short_count,
  output logic [31:0] last_seq,
  output logic        pkt_done
);

  localparam logic [10:0] LAST_BYTE = 11'(4 + 6 * SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEQ     = 2'd1,
    S_DATA    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q;
  logic [10:0] byte_cnt_q;
  logic [2:0]  pair_cnt_q;
  logic [23:0] rx_seq_q;
  logic [39:0] shift_q;
  logic [31:0] expected_seq_q;
  logic        seeded_q;
  logic        active_q;

  logic        wrreq_q;
  logic [47:0] wdata_q;
  logic        seq_error_q;
  logic [15:0] seq_err_count_q;
  logic [15:0] overflow_count_q;
  logic [7:0]  short_count_q;
  logic [31:0] last_seq_q;
  logic        pkt_done_q;

  logic [31:0] seq_word_d;
  logic [47:0] word_d;
  logic        seq_mismatch_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Candidate sequence number and data word formed with the byte currently on the bus.
  always_comb begin
    seq_word_d     = {rx_seq_q, udp_rx_data};
    word_d         = {shift_q, udp_rx_data};
    seq_mismatch_d = seeded_q && (seq_word_d != expected_seq_q);
  end

  // Packet parser FSM with all status outputs registered.
  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      byte_cnt_q       <= 11'd0;
      pair_cnt_q       <= 3'd0;
      rx_seq_q         <= 24'd0;
      shift_q          <= 40'd0;
      expected_seq_q   <= 32'd0;
      seeded_q         <= 1'b0;
      active_q         <= 1'b0;
      wrreq_q          <= 1'b0;
      wdata_q          <= 48'd0;
      seq_error_q      <= 1'b0;
      seq_err_count_q  <= 16'd0;
      overflow_count_q <= 16'd0;
      short_count_q    <= 8'd0;
      last_seq_q       <= 32'd0;
      pkt_done_q       <= 1'b0;
    end else begin
      wrreq_q     <= 1'b0;
      seq_error_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      active_q    <= udp_rx_active;
      if (!run) begin
        state_q  <= S_IDLE;
        seeded_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // A start needs a low cycle first, so a packet already in flight when run returns is skipped.
            if (udp_rx_active) begin
              if (!active_q && (to_port == RX_PORT)) begin
                state_q    <= S_SEQ;
                rx_seq_q   <= {16'd0, udp_rx_data};
                byte_cnt_q <= 11'd1;
              end else begin
                state_q <= S_DISCARD;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_SEQ: begin
            if (!udp_rx_active) begin
              short_count_q <= sat_inc8(short_count_q);
              state_q       <= S_IDLE;
            end else begin
              rx_seq_q   <= seq_word_d[23:0];
              byte_cnt_q <= byte_cnt_q + 11'd1;
              if (byte_cnt_q == 11'd3) begin
                seq_error_q <= seq_mismatch_d;
                if (seq_mismatch_d) begin
                  seq_err_count_q <= sat_inc16(seq_err_count_q);
                end else begin
                  seq_err_count_q <= seq_err_count_q;
                end
                expected_seq_q <= seq_word_d + 32'd1;
                last_seq_q     <= seq_word_d;
                seeded_q       <= 1'b1;
                pair_cnt_q     <= 3'd0;
                state_q        <= S_DATA;
              end else begin
                state_q <= S_SEQ;
              end
            end
          end
          S_DATA: begin
            if (!udp_rx_active) begin
              short_count_q <= sat_inc8(short_count_q);
              state_q       <= S_IDLE;
            end else begin
              shift_q    <= word_d[39:0];
              byte_cnt_q <= byte_cnt_q + 11'd1;
              if (pair_cnt_q == 3'd5) begin
                pair_cnt_q <= 3'd0;
                if (fifo_full) begin
                  overflow_count_q <= sat_inc16(overflow_count_q);
                end else begin
                  wrreq_q <= 1'b1;
                  wdata_q <= word_d;
                end
              end else begin
                pair_cnt_q <= pair_cnt_q + 3'd1;
              end
              if (byte_cnt_q == LAST_BYTE) begin
                pkt_done_q <= 1'b1;
                state_q    <= S_DISCARD;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DISCARD: begin
            if (!udp_rx_active) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DISCARD;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign fifo_wrreq     = wrreq_q;
  assign fifo_wdata     = wdata_q;
  assign seq_error      = seq_error_q;
  assign seq_err_count  = seq_err_count_q;
  assign overflow_count = overflow_count_q;
  assign short_count    = short_count_q;
  assign last_seq       = last_seq_q;
  assign pkt_done       = pkt_done_q;

endmodule

// File: tb/tb_sdr_duc_receive.sv
// Self-checking bench for sdr_duc_receive: random payloads driven byte by byte and compared
// against a packet-level reference model of words, sequence tracking and status counters.
module tb_sdr_duc_receive;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        udp_rx_active;
  logic [7:0]  udp_rx_data;
  logic [15:0] to_port;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [47:0] fifo_wdata;
  logic        seq_error;
  logic [15:0] seq_err_count;
  logic [15:0] overflow_count;
  logic [7:0]  short_count;
  logic [31:0] last_seq;
  logic        pkt_done;

  int checks = 0;
  int errors = 0;

  logic [47:0] got_q[$];
  int          dones = 0;
  int          seqerrs = 0;

  logic        m_seeded = 1'b0;
  logic [31:0] m_exp = 32'd0;
  int          m_seqerr = 0;
  int          m_ovf = 0;
  int          m_short = 0;
  logic [31:0] m_last = 32'd0;

  always #5 clk = ~clk;

  sdr_duc_receive dut (
    .rx_clock      (clk),
    .reset_n       (reset_n),
    .run           (run),
    .udp_rx_active (udp_rx_active),
    .udp_rx_data   (udp_rx_data),
    .to_port       (to_port),
    .fifo_full     (fifo_full),
    .fifo_wrreq    (fifo_wrreq),
    .fifo_wdata    (fifo_wdata),
    .seq_error     (seq_error),
    .seq_err_count (seq_err_count),
    .overflow_count(overflow_count),
    .short_count   (short_count),
    .last_seq      (last_seq),
    .pkt_done      (pkt_done)
  );

  always @(negedge clk) begin
    if (fifo_wrreq) got_q.push_back(fifo_wdata);
    if (pkt_done) dones++;
    if (seq_error) seqerrs++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one payload and checks it against the packet-level model.
  // full_lo..full_hi: pairs presented with fifo_full high; drop_pair >= 0 drops run at that pair.
  task automatic send_pkt(input string tag, input logic [15:0] port, input logic [31:0] seq,
                          input int len, input int full_lo, input int full_hi,
                          input int drop_pair, input bit force_pair0);
    logic [7:0]  b[];
    logic [47:0] exp_q[$];
    logic [47:0] w;
    int          npairs;
    int          exp_done;
    int          exp_serr;
    int          start;
    int          d0;
    int          e0;
    bit          accepted;
    b = new[len];
    for (int i = 0; i < len; i++) begin
      if (i < 4) b[i] = seq[8*(3-i) +: 8];
      else b[i] = 8'($urandom);
    end
    if (force_pair0 && len >= 10) begin
      b[4] = 8'h12; b[5] = 8'h34; b[6] = 8'h56;
      b[7] = 8'hAB; b[8] = 8'hCD; b[9] = 8'hEF;
    end
    exp_done = 0;
    exp_serr = 0;
    accepted = run && (port == 16'd1029);
    if (!run) m_seeded = 1'b0;
    if (accepted) begin
      if (len < 4) begin
        m_short++;
      end else begin
        if (m_seeded && seq != m_exp) begin
          exp_serr = 1;
          m_seqerr++;
        end
        m_exp = seq + 32'd1;
        m_last = seq;
        m_seeded = 1'b1;
        npairs = (len - 4) / 6;
        if (npairs > 240) npairs = 240;
        if (drop_pair >= 0) npairs = drop_pair;
        for (int p = 0; p < npairs; p++) begin
          if (p >= full_lo && p <= full_hi) begin
            m_ovf++;
          end else begin
            w = 48'd0;
            for (int k = 0; k < 6; k++) w = {w[39:0], b[4 + 6*p + k]};
            exp_q.push_back(w);
          end
        end
        if (drop_pair >= 0) m_seeded = 1'b0;
        else if (len >= 1444) exp_done = 1;
        else m_short++;
      end
    end
    start = got_q.size();
    d0 = dones;
    e0 = seqerrs;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      udp_rx_active = 1'b1;
      udp_rx_data = b[i];
      to_port = port;
      fifo_full = (i >= 4) && ((i - 4) / 6 >= full_lo) && ((i - 4) / 6 <= full_hi);
      if (drop_pair >= 0 && i == 4 + 6 * drop_pair) run = 1'b0;
      if (drop_pair >= 0 && i == 4 + 6 * drop_pair + 20) run = 1'b1;
    end
    @(negedge clk);
    udp_rx_active = 1'b0;
    fifo_full = 1'b0;
    udp_rx_data = 8'd0;
    repeat (4) @(negedge clk);
    check({tag, "_strobes"}, 64'(got_q.size() - start), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && start + j < got_q.size(); j++)
      check({tag, "_word"}, 64'(got_q[start + j]), 64'(exp_q[j]));
    check({tag, "_pkt_done"}, 64'(dones - d0), 64'(exp_done));
    check({tag, "_seq_error"}, 64'(seqerrs - e0), 64'(exp_serr));
    check({tag, "_seq_err_count"}, 64'(seq_err_count), 64'(m_seqerr));
    check({tag, "_overflow_count"}, 64'(overflow_count), 64'(m_ovf));
    check({tag, "_short_count"}, 64'(short_count), 64'(m_short));
    check({tag, "_last_seq"}, 64'(last_seq), 64'(m_last));
  endtask

  initial begin
    int s;
    logic [31:0] rs;
    reset_n = 1'b0;
    run = 1'b0;
    udp_rx_active = 1'b0;
    udp_rx_data = 8'd0;
    to_port = 16'd0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    check("rst_wdata", 64'(fifo_wdata), 64'd0);
    check("rst_counts", 64'({seq_err_count, overflow_count, short_count}), 64'd0);
    check("rst_last_seq", 64'(last_seq), 64'd0);
    check("rst_pulses", 64'({seq_error, pkt_done}), 64'd0);
    reset_n = 1'b1;
    run = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic full packet with known first pair
    s = got_q.size();
    send_pkt("t1", 16'd1029, 32'h5, 1444, -1, -1, -1, 1'b1);
    check("t1_first_word", 64'(got_q[s]), 64'h123456ABCDEF);
    check("t1_240", 64'(got_q.size() - s), 64'd240);
    check("t1_last_seq5", 64'(last_seq), 64'd5);

    // 2: sequence continuity and wrap
    send_pkt("t2a", 16'd1029, 32'h6, 1444, -1, -1, -1, 1'b0);
    send_pkt("t2b", 16'd1029, 32'h8, 1444, -1, -1, -1, 1'b0);
    send_pkt("t2c", 16'd1029, 32'h9, 1444, -1, -1, -1, 1'b0);
    check("t2_one_error", 64'(seq_err_count), 64'd1);
    send_pkt("t2d", 16'd1029, 32'hFFFF_FFFF, 1444, -1, -1, -1, 1'b0);
    send_pkt("t2e", 16'd1029, 32'h0, 1444, -1, -1, -1, 1'b0);

    // 3: wrong port, then run low
    send_pkt("t3a", 16'd1028, 32'($urandom), 1444, -1, -1, -1, 1'b0);
    @(negedge clk);
    run = 1'b0;
    send_pkt("t3b", 16'd1029, 32'($urandom), 1444, -1, -1, -1, 1'b0);
    run = 1'b1;
    @(negedge clk);
    send_pkt("t3c", 16'd1029, 32'($urandom), 1444, -1, -1, -1, 1'b0);

    // 4: short packets and over-length packet
    s = got_q.size();
    send_pkt("t4a", 16'd1029, m_exp, 1000, -1, -1, -1, 1'b0);
    check("t4_166", 64'(got_q.size() - s), 64'd166);
    check("t4_short1", 64'(short_count), 64'd1);
    send_pkt("t4b", 16'd1029, m_exp, 1444, -1, -1, -1, 1'b0);
    send_pkt("t4c", 16'd1029, 32'($urandom), 3, -1, -1, -1, 1'b0);
    send_pkt("t4d", 16'd1029, m_exp, 1450, -1, -1, -1, 1'b0);

    // 5: FIFO full window on pairs 10..19
    s = got_q.size();
    send_pkt("t5", 16'd1029, m_exp, 1444, 10, 19, -1, 1'b0);
    check("t5_230", 64'(got_q.size() - s), 64'd230);
    check("t5_ovf10", 64'(overflow_count), 64'd10);

    // 6: run dropped mid-packet, then reseed on an arbitrary sequence number
    send_pkt("t6a", 16'd1029, m_exp, 1444, -1, -1, 100, 1'b0);
    rs = 32'($urandom);
    send_pkt("t6b", 16'd1029, rs, 1444, -1, -1, -1, 1'b0);
    check("t6_reseed", 64'(last_seq), 64'(rs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
